// File: rtl/cpu16_pkg.sv
// Shared types and encodings for the 16-bit multi-cycle CPU controller.
package cpu16_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ANDI  = 4'h2;
  localparam logic [3:0] OP_ORI   = 4'h3;
  localparam logic [3:0] OP_LW    = 4'h4;
  localparam logic [3:0] OP_SW    = 4'h5;
  localparam logic [3:0] OP_BEQ   = 4'h6;
  localparam logic [3:0] OP_BNE   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_LOGIC = 2'b11;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_HALT    = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;
  localparam logic [1:0] ERR_MEMTO   = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_t;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_load_init;
    logic       reg_dst;
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       busy;
    logic       halted;
  } ctrl_t;

  // Opcodes 8..E are unassigned; everything else decodes.
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= OP_BNE) || (op == OP_HALT);
  endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Controller <-> datapath bundle: status in, control lines and counters out.
interface multicycle_control_unit_if;
  logic        Start;
  logic [3:0]  Opcode;
  logic        Zero;
  logic        MemReady;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCLoadInit;
  logic [15:0] PCInit;
  logic        RegDst;
  logic        Branch;
  logic        MemRead;
  logic        MemToReg;
  logic        MemWrite;
  logic        ALUSrc;
  logic        RegWrite;
  logic [1:0]  ALUOp;
  logic        Busy;
  logic        Halted;
  logic [1:0]  ErrCode;
  logic [15:0] InstrCount;

  modport master (
    input  Start, Opcode, Zero, MemReady,
    output IRWrite, PCWrite, PCLoadInit, PCInit, RegDst, Branch, MemRead,
           MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp, Busy, Halted,
           ErrCode, InstrCount
  );

  modport slave (
    output Start, Opcode, Zero, MemReady,
    input  IRWrite, PCWrite, PCLoadInit, PCInit, RegDst, Branch, MemRead,
           MemToReg, MemWrite, ALUSrc, RegWrite, ALUOp, Busy, Halted,
           ErrCode, InstrCount
  );
endinterface

// File: rtl/mcu_output_decode.sv
// Combinational control-word decode from the current state and latched opcode.
module mcu_output_decode
  import cpu16_pkg::*;
(
  input  state_t     state_i,
  input  logic [3:0] op_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_IDLE: ctrl_o.pc_load_init = 1'b1;
      ST_FETCH: begin
        ctrl_o.busy     = 1'b1;
        ctrl_o.ir_write = 1'b1;
      end
      ST_DECODE: ctrl_o.busy = 1'b1;
      ST_EXEC: begin
        ctrl_o.busy = 1'b1;
        case (op_i)
          OP_RTYPE: begin
            ctrl_o.reg_dst = 1'b1;
            ctrl_o.alu_op  = ALU_FUNCT;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALU_ADD;
          end
          OP_ANDI, OP_ORI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALU_LOGIC;
          end
          // The datapath picks target vs sequential PC from Branch and Zero.
          OP_BEQ, OP_BNE: begin
            ctrl_o.branch   = 1'b1;
            ctrl_o.alu_op   = ALU_SUB;
            ctrl_o.pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        ctrl_o.busy      = 1'b1;
        ctrl_o.alu_src   = 1'b1;
        ctrl_o.alu_op    = ALU_ADD;
        ctrl_o.mem_read  = (op_i == OP_LW);
        ctrl_o.mem_write = (op_i == OP_SW);
      end
      ST_WB: begin
        ctrl_o.busy      = 1'b1;
        ctrl_o.reg_write = 1'b1;
        ctrl_o.pc_write  = 1'b1;
        case (op_i)
          OP_RTYPE: begin
            ctrl_o.reg_dst = 1'b1;
            ctrl_o.alu_op  = ALU_FUNCT;
          end
          OP_LW: ctrl_o.mem_to_reg = 1'b1;
          OP_ADDI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALU_ADD;
          end
          OP_ANDI, OP_ORI: begin
            ctrl_o.alu_src = 1'b1;
            ctrl_o.alu_op  = ALU_LOGIC;
          end
          default: ;
        endcase
      end
      ST_HALT: ctrl_o.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with memory timeout and halt.
module multicycle_control_unit
  import cpu16_pkg::*;
#(
  parameter int          MEM_TIMEOUT = 8,
  parameter logic [15:0] PC_RESET    = 16'd11
) (
  input  logic                       Clock,
  input  logic                       Reset_n,
  multicycle_control_unit_if.master  bus
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [7:0]  wait_q, wait_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  err_q, err_d;
  ctrl_t       ctrl;
  logic        sw_done;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    wait_d  = wait_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE:  if (bus.Start) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_DECODE;
      ST_DECODE: begin
        op_d = bus.Opcode;
        if (!op_is_legal(bus.Opcode)) begin
          state_d = ST_HALT;
          err_d   = ERR_ILLEGAL;
        end else if (bus.Opcode == OP_HALT) begin
          state_d = ST_HALT;
          err_d   = ERR_HALT;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = ST_MEM;
        end else if (op_q == OP_BEQ || op_q == OP_BNE) begin
          state_d = ST_FETCH;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        if (bus.MemReady) begin
          wait_d = '0;
          if (op_q == OP_SW) begin
            state_d = ST_FETCH;
            cnt_d   = cnt_q + 16'd1;
          end else begin
            state_d = ST_WB;
          end
        end else if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = ST_HALT;
          err_d   = ERR_MEMTO;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      ST_WB: begin
        state_d = ST_FETCH;
        cnt_d   = cnt_q + 16'd1;
      end
      ST_HALT: ;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      wait_q  <= '0;
      cnt_q   <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  mcu_output_decode u_dec (
    .state_i (state_q),
    .op_i    (op_q),
    .ctrl_o  (ctrl)
  );

  // A store retires in the MEM cycle that sees MemReady, so its PC pulse
  // is the one output qualified by a live input.
  assign sw_done = (state_q == ST_MEM) && (op_q == OP_SW) && bus.MemReady;

  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.PCWrite    = ctrl.pc_write | sw_done;
  assign bus.PCLoadInit = ctrl.pc_load_init;
  assign bus.PCInit     = PC_RESET;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.Branch     = ctrl.branch;
  assign bus.MemRead    = ctrl.mem_read;
  assign bus.MemToReg   = ctrl.mem_to_reg;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.ALUSrc     = ctrl.alu_src;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.ALUOp      = ctrl.alu_op;
  assign bus.Busy       = ctrl.busy;
  assign bus.Halted     = ctrl.halted;
  assign bus.ErrCode    = err_q;
  assign bus.InstrCount = cnt_q;

endmodule
